// File: rtl/fb_pkg.sv
// Shared constants, types and helpers for the framebuffer scan arbiter.
// Geometry: 640x480 visible in an 800x525 raster; 160x120 RGB444 framebuffer,
// one framebuffer pixel per 4x4 screen block.
package fb_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_WORDS = FB_W * FB_H;

  localparam int unsigned RGB_W    = 12;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned X_W      = 11;
  localparam int unsigned Y_W      = 10;

  typedef logic [RGB_W-1:0]  rgb_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Linear framebuffer address of a block
  function automatic addr_t block_addr(input logic [7:0] row, input logic [8:0] col);
    return ADDR_W'(row) * ADDR_W'(FB_W) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/fb_scan_arbiter_if.sv
// Bus bundle between the scan arbiter, the single-port framebuffer RAM, the
// draw writer and the clear requester.
//   mem_addr/mem_we/mem_wdata : RAM command (arbiter -> RAM)
//   mem_rdata                 : RAM read data, one cycle after the address
//   wr_req/wr_addr/wr_data    : writer request, held until wr_ack
//   wr_ack                    : one-cycle pulse, write completes in that cycle
//   clr_req/clr_color         : clear start pulse and fill colour
//   busy                      : clear in progress
// Modport slave is the arbiter side; master is the RAM/writer side.
interface fb_scan_arbiter_if;
  import fb_pkg::*;

  addr_t mem_addr;
  logic  mem_we;
  rgb_t  mem_wdata;
  rgb_t  mem_rdata;
  logic  wr_req;
  addr_t wr_addr;
  rgb_t  wr_data;
  logic  wr_ack;
  logic  clr_req;
  rgb_t  clr_color;
  logic  busy;

  modport slave (
    output mem_addr, mem_we, mem_wdata, wr_ack, busy,
    input  mem_rdata, wr_req, wr_addr, wr_data, clr_req, clr_color
  );

  modport master (
    input  mem_addr, mem_we, mem_wdata, wr_ack, busy,
    output mem_rdata, wr_req, wr_addr, wr_data, clr_req, clr_color
  );

endinterface

// File: rtl/fb_scan_addr_gen.sv
// Display-slot detector and prefetch address generator.
// A slot is a curr_x[1:0]==1 cycle in which the scan must fetch the block it
// will show next: the block to the right on an active line, or block 0 of the
// next line's row at the end of the line (including wrap from the last line).
//   curr_x  in  11  scan column
//   curr_y  in  10  scan line
//   slot_c  out 1   this cycle is a display slot
//   addr_c  out 15  block address to read in the slot
module fb_scan_addr_gen
  import fb_pkg::*;
(
  input  logic [X_W-1:0] curr_x,
  input  logic [Y_W-1:0] curr_y,
  output logic           slot_c,
  output addr_t          addr_c
);

  logic [Y_W-1:0] ny;
  logic           phase1;

  always_comb begin
    ny     = (curr_y == Y_W'(V_TOTAL - 1)) ? '0 : curr_y + Y_W'(1);
    phase1 = (curr_x[1:0] == 2'd1);
    slot_c = 1'b0;
    addr_c = '0;
    if (phase1 && (curr_x < X_W'(H_ACTIVE - 4)) && (curr_y < Y_W'(V_ACTIVE))) begin
      // Fetch the next block along the current line
      slot_c = 1'b1;
      addr_c = block_addr(curr_y[Y_W-1:2], curr_x[X_W-1:2]) + ADDR_W'(1);
    end else if (phase1 && (curr_x == X_W'(H_TOTAL - 3)) && (ny < Y_W'(V_ACTIVE))) begin
      // Fetch the first block of the upcoming line
      slot_c = 1'b1;
      addr_c = block_addr(ny[Y_W-1:2], 9'd0);
    end
  end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Shares one single-port framebuffer RAM between the VGA scan (fixed-deadline
// reads), a draw writer (req/ack) and a full-screen clear sequencer, and drives
// the pixel colour back to vga_out.
//   clk, rst            clock and synchronous active-high reset
//   curr_x, curr_y      scan position from vga_out
//   red, green, blue    pixel colour to vga_out (combinational from pix_cur)
//   bus                 RAM / writer / clear bundle (slave side)
module fb_scan_arbiter
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [X_W-1:0]   curr_x,
  input  logic [Y_W-1:0]   curr_y,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  fb_scan_arbiter_if.slave bus
);

  state_t state, state_next;
  addr_t  cnt, cnt_next;
  rgb_t   clr_q, clr_next;
  logic   busy_q, busy_next;
  addr_t  addr_q;
  logic   slot_q;
  rgb_t   pix_cur, pix_next;

  logic   slot_c;
  addr_t  slot_addr_c;
  addr_t  addr_c;
  logic   we_c;
  rgb_t   wdata_c;
  logic   ack_c;
  rgb_t   rgb_c;

  fb_scan_addr_gen u_addr_gen (
    .curr_x (curr_x),
    .curr_y (curr_y),
    .slot_c (slot_c),
    .addr_c (slot_addr_c)
  );

  // State, clear counter, held address and pixel pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_q    <= '0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      slot_q   <= 1'b0;
      pix_cur  <= '0;
      pix_next <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      clr_q  <= clr_next;
      busy_q <= busy_next;
      addr_q <= addr_c;
      slot_q <= slot_c;
      if (slot_q) begin
        pix_next <= bus.mem_rdata;
      end
      // Swap in the prefetched block on the last pixel of the current block
      if (curr_x[1:0] == 2'd3) begin
        pix_cur <= pix_next;
      end
    end
  end

  // Arbitration and clear FSM; the display slot always owns the RAM.
  // Outputs are gated during reset so an aborted clear cannot land one more word.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_next   = clr_q;
    busy_next  = busy_q;
    addr_c     = addr_q;
    we_c       = 1'b0;
    wdata_c    = '0;
    ack_c      = 1'b0;
    if (!rst) begin
      if (slot_c) begin
        addr_c = slot_addr_c;
      end
      unique case (state)
        IDLE: begin
          if (bus.clr_req) begin
            clr_next   = bus.clr_color;
            cnt_next   = '0;
            busy_next  = 1'b1;
            state_next = CLEAR;
          end else if (bus.wr_req && !slot_c) begin
            ack_c = 1'b1;
            // Out-of-range writes are acknowledged and dropped
            if (bus.wr_addr < ADDR_W'(FB_WORDS)) begin
              addr_c  = bus.wr_addr;
              wdata_c = bus.wr_data;
              we_c    = 1'b1;
            end
          end
        end
        CLEAR: begin
          if (!slot_c) begin
            addr_c  = cnt;
            wdata_c = clr_q;
            we_c    = 1'b1;
            if (cnt == ADDR_W'(FB_WORDS - 1)) begin
              cnt_next   = '0;
              busy_next  = 1'b0;
              state_next = IDLE;
            end else begin
              cnt_next = cnt + ADDR_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Blank outside the visible area
  always_comb begin
    rgb_c = '0;
    if ((curr_x < X_W'(H_ACTIVE)) && (curr_y < Y_W'(V_ACTIVE))) begin
      rgb_c = pix_cur;
    end
  end

  assign red           = rgb_c[11:8];
  assign green         = rgb_c[7:4];
  assign blue          = rgb_c[3:0];
  assign bus.mem_addr  = addr_c;
  assign bus.mem_we    = we_c;
  assign bus.mem_wdata = wdata_c;
  assign bus.wr_ack    = ack_c;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter: raster counter model, behavioural
// 19200x12 RAM, immediate assertions at every comparison point.
module tb_fb_scan_arbiter;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] curr_x;
  logic [9:0]  curr_y;
  logic [3:0]  red, green, blue;

  logic        load;
  logic [10:0] load_x;
  logic [9:0]  load_y;
  logic        pre_en;
  logic [14:0] pre_addr;
  logic [11:0] pre_data;
  logic [11:0] ram [19200];

  int n_checks = 0;
  int n_fail   = 0;

  fb_scan_arbiter_if bus ();

  fb_scan_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .curr_x (curr_x),
    .curr_y (curr_y),
    .red    (red),
    .green  (green),
    .blue   (blue),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Free-running 800x525 raster counter with a load for jumping around the frame
  always @(posedge clk) begin
    if (load) begin
      curr_x <= load_x;
      curr_y <= load_y;
    end else if (curr_x == 11'd799) begin
      curr_x <= 11'd0;
      curr_y <= (curr_y == 10'd524) ? 10'd0 : curr_y + 10'd1;
    end else begin
      curr_x <= curr_x + 11'd1;
    end
  end

  // Single-port RAM, read data one cycle after the address; bench preload port
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xy(input int x, input int y, input string tag);
    int k = 0;
    while (!(32'(curr_x) == x && 32'(curr_y) == y) && k < 2000) begin
      tick();
      k++;
    end
    check(tag, 32'(curr_y) * 1024 + 32'(curr_x), y * 1024 + x);
  endtask

  function automatic bit tb_slot(input int x, input int y);
    int ny;
    ny = (y == 524) ? 0 : y + 1;
    return (x % 4 == 1) && ((x < 636 && y < 480) || (x == 797 && ny < 480));
  endfunction

  function automatic logic [31:0] rgb();
    return 32'({red, green, blue});
  endfunction

  initial begin
    int nw, bad_addr, bad_data, acks, slot_we, bad_lo, bad_hi, k;
    rst = 1'b1; load = 1'b1; load_x = 11'd790; load_y = 10'd524;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_req = 1'b0; bus.clr_color = '0;
    pre_en = 1'b1; pre_addr = 15'd0; pre_data = 12'h256;
    tick();
    pre_addr = 15'd1; pre_data = 12'hABC;
    tick();
    pre_en = 1'b0;
    tick();

    // Reset state
    check("rst rgb", rgb(), 'h0);
    check("rst mem_we", 32'(bus.mem_we), 'h0);
    check("rst mem_addr", 32'(bus.mem_addr), 'h0);
    check("rst wr_ack", 32'(bus.wr_ack), 'h0);
    check("rst busy", 32'(bus.busy), 'h0);
    rst = 1'b0; load = 1'b0;

    // Prefetch of block 0 at the end of the last line, then line 0
    wait_xy(797, 524, "reach 797/524");
    check("prefetch addr", 32'(bus.mem_addr), 'h0);
    check("prefetch we", 32'(bus.mem_we), 'h0);
    wait_xy(0, 0, "reach 0/0");
    for (int x = 0; x < 8; x++) begin
      check("line0 rgb", rgb(), (x < 4) ? 'h256 : 'hABC);
      tick();
    end
    wait_xy(640, 0, "reach 640/0");
    for (int x = 640; x < 800; x++) begin
      check("blank rgb", rgb(), 'h0);
      tick();
    end

    // Writer against a display slot on line 1
    wait_xy(1, 1, "reach 1/1");
    bus.wr_req = 1'b1; bus.wr_addr = 15'd161; bus.wr_data = 12'hF00;
    #1;
    check("slot wr_ack", 32'(bus.wr_ack), 'h0);
    check("slot mem_we", 32'(bus.mem_we), 'h0);
    tick();
    check("wr wr_ack", 32'(bus.wr_ack), 'h1);
    check("wr mem_we", 32'(bus.mem_we), 'h1);
    check("wr mem_addr", 32'(bus.mem_addr), 'd161);
    check("wr mem_wdata", 32'(bus.mem_wdata), 'hF00);
    tick();
    bus.wr_req = 1'b0;

    // Written block shows at x=4..7 of y=4
    load = 1'b1; load_x = 11'd790; load_y = 10'd3;
    tick();
    load = 1'b0;
    wait_xy(4, 4, "reach 4/4");
    for (int x = 4; x < 8; x++) begin
      check("wr block rgb", rgb(), 'hF00);
      tick();
    end

    // Out-of-range write: acked, dropped
    k = 0;
    while (curr_x[1:0] != 2'd2 && k < 8) begin tick(); k++; end
    bus.wr_req = 1'b1; bus.wr_addr = 15'd19200; bus.wr_data = 12'hFFF;
    #1;
    check("oor wr_ack", 32'(bus.wr_ack), 'h1);
    check("oor mem_we", 32'(bus.mem_we), 'h0);
    tick();
    bus.wr_req = 1'b0;

    // Frame wrap with fb[0]=123
    pre_en = 1'b1; pre_addr = 15'd0; pre_data = 12'h123;
    load = 1'b1; load_x = 11'd790; load_y = 10'd524;
    tick();
    pre_en = 1'b0; load = 1'b0;
    wait_xy(797, 524, "reach wrap 797");
    check("wrap addr", 32'(bus.mem_addr), 'h0);
    check("wrap we", 32'(bus.mem_we), 'h0);
    wait_xy(0, 0, "reach wrap 0/0");
    check("wrap rgb", rgb(), 'h123);

    // Full clear with a concurrent writer
    bus.clr_req = 1'b1; bus.clr_color = 12'h0F0;
    bus.wr_req = 1'b1; bus.wr_addr = 15'd5; bus.wr_data = 12'hABC;
    #1;
    check("clr beats wr", 32'(bus.wr_ack), 'h0);
    tick();
    bus.clr_req = 1'b0; bus.clr_color = 12'h000;
    check("clr busy rise", 32'(bus.busy), 'h1);
    nw = 0; bad_addr = 0; bad_data = 0; acks = 0; slot_we = 0;
    for (int i = 0; i < 40000 && bus.busy; i++) begin
      if (bus.mem_we) begin
        if (32'(bus.mem_addr) != nw) bad_addr++;
        if (bus.mem_wdata != 12'h0F0) bad_data++;
        if (tb_slot(32'(curr_x), 32'(curr_y))) slot_we++;
        nw++;
      end
      if (bus.wr_ack) acks++;
      tick();
    end
    check("clr writes", 32'(nw), 'd19200);
    check("clr busy fall", 32'(bus.busy), 'h0);
    check("clr addr seq", 32'(bad_addr), 'h0);
    check("clr data", 32'(bad_data), 'h0);
    check("clr no ack", 32'(acks), 'h0);
    check("clr slot we", 32'(slot_we), 'h0);
    bad_lo = 0;
    for (int i = 0; i < 19200; i++) if (ram[i] !== 12'h0F0) bad_lo++;
    check("clr words", 32'(bad_lo), 'h0);
    k = 0;
    while (!bus.wr_ack && k < 8) begin tick(); k++; end
    check("wr after clr", 32'(bus.wr_ack), 'h1);
    tick();
    bus.wr_req = 1'b0;
    check("wr after clr ram", 32'(ram[5]), 'hABC);

    // Clear aborted by reset after 5000 words
    bus.clr_req = 1'b1; bus.clr_color = 12'h00F;
    tick();
    bus.clr_req = 1'b0;
    check("clr2 busy", 32'(bus.busy), 'h1);
    nw = 0;
    for (int i = 0; i < 10000 && nw < 5000; i++) begin
      if (bus.mem_we) nw++;
      tick();
    end
    check("clr2 count", 32'(nw), 'd5000);
    rst = 1'b1;
    #1;
    check("rst gates we", 32'(bus.mem_we), 'h0);
    tick();
    check("abort busy", 32'(bus.busy), 'h0);
    rst = 1'b0;
    tick();
    check("abort idle we", 32'(bus.mem_we), 'h0);
    bad_lo = 0; bad_hi = 0;
    for (int i = 0; i < 5000; i++) if (ram[i] !== 12'h00F) bad_lo++;
    for (int i = 5000; i < 19200; i++) if (ram[i] !== 12'h0F0) bad_hi++;
    check("abort low words", 32'(bad_lo), 'h0);
    check("abort high words", 32'(bad_hi), 'h0);

    // New clear restarts from address 0
    bus.clr_req = 1'b1; bus.clr_color = 12'h555;
    tick();
    bus.clr_req = 1'b0;
    k = 0;
    while (!bus.mem_we && k < 20) begin tick(); k++; end
    check("restart we", 32'(bus.mem_we), 'h1);
    check("restart addr", 32'(bus.mem_addr), 'h0);
    check("restart data", 32'(bus.mem_wdata), 'h555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
